idli_alu_m: RTL

//   Nibble-serial 16-bit ALU sitting directly downstream of the general register file.

---
 rtl/idli_pkg.sv | 27 ++
 rtl/idli_alu_if.sv | 25 ++
 rtl/idli_alu_nib_m.sv | 47 ++++
 rtl/idli_alu_m.sv | 119 +++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core's ALU datapath.
// Optional shift ops are enabled by defining IDLI_ALU_SHIFT_EN.
package idli_pkg;

   localparam int unsigned ALU_NIBBLES = 4;

   typedef enum logic [2:0] {
      AluAdd  = 3'd0,
      AluSub  = 3'd1,
      AluAnd  = 3'd2,
      AluOr   = 3'd3,
      AluXor  = 3'd4,
      AluAndn = 3'd5,
      AluShl  = 3'd6,
      AluShlc = 3'd7
   } alu_op_t;

   // Ops whose condition flag comes from the slice carry-out rather than result != 0.
   function automatic logic alu_op_cond_from_carry(alu_op_t op);
`ifdef IDLI_ALU_SHIFT_EN
      return (op == AluAdd) || (op == AluSub) || (op == AluShl) || (op == AluShlc);
`else
      return (op == AluAdd) || (op == AluSub);
`endif
   endfunction

endpackage

// File: rtl/idli_alu_if.sv
// Nibble-serial ALU port bundle between the register file sequencing and idli_alu_m.
interface idli_alu_if;
   import idli_pkg::*;

   logic       i_alu_start;
   alu_op_t    i_alu_op;
   logic [3:0] i_alu_b_data;
   logic [3:0] i_alu_c_data;
   logic       o_alu_busy;
   logic       o_alu_vld;
   logic [3:0] o_alu_data;
   logic       o_alu_last;
   logic       o_alu_cond;

   modport master (
      output i_alu_start, i_alu_op, i_alu_b_data, i_alu_c_data,
      input  o_alu_busy, o_alu_vld, o_alu_data, o_alu_last, o_alu_cond
   );

   modport slave (
      input  i_alu_start, i_alu_op, i_alu_b_data, i_alu_c_data,
      output o_alu_busy, o_alu_vld, o_alu_data, o_alu_last, o_alu_cond
   );

endinterface

// File: rtl/idli_alu_nib_m.sv
// Combinational 4-bit ALU slice; the caller supplies carry-in and stores carry-out.
// Shift ops are built only when IDLI_ALU_SHIFT_EN is defined.
module idli_alu_nib_m
   import idli_pkg::*;
(
   input  logic [3:0] i_b,
   input  logic [3:0] i_c,
   input  alu_op_t    i_op,
   input  logic       i_cin,
   output logic [3:0] o_data,
   output logic       o_cout
);

   logic [4:0] sum;

   always_comb begin
      sum    = '0;
      o_data = '0;
      o_cout = 1'b0;
      case (i_op)
         AluAdd: begin
            sum    = {1'b0, i_b} + {1'b0, i_c} + {4'b0, i_cin};
            o_data = sum[3:0];
            o_cout = sum[4];
         end
         AluSub: begin
            sum    = {1'b0, i_b} + {1'b0, ~i_c} + {4'b0, i_cin};
            o_data = sum[3:0];
            o_cout = sum[4];
         end
         AluAnd:  o_data = i_b & i_c;
         AluOr:   o_data = i_b | i_c;
         AluXor:  o_data = i_b ^ i_c;
         AluAndn: o_data = i_b & ~i_c;
         AluShl, AluShlc: begin
`ifdef IDLI_ALU_SHIFT_EN
            o_data = {i_b[2:0], i_cin};
            o_cout = i_b[3];
`else
            o_data = i_b;
`endif
         end
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/idli_alu_m.sv
// Nibble-serial 16-bit ALU: result nibble leaves in the same cycle its operands arrive.
// Holds sequencing, carry, zero and condition state; IDLI_ALU_SHIFT_EN enables SHL/SHLC.
module idli_alu_m
   import idli_pkg::*;
#(
   parameter int unsigned NIBBLES = ALU_NIBBLES
) (
   input  logic      i_alu_gck,
   input  logic      i_alu_rst_n,
   idli_alu_if.slave alu
);

   localparam int unsigned CtrW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   logic            busy_q, busy_d;
   logic [CtrW-1:0] ctr_q, ctr_d;
   alu_op_t         op_q, op_d;
   logic            carry_q, carry_d;
   logic            zero_q, zero_d;
   logic            cond_q, cond_d;

   logic            start_go;
   logic            vld;
   logic            last;
   alu_op_t         op_cur;
   logic            cin;
   logic [3:0]      nib_data;
   logic            nib_cout;
   logic            zero_acc;
   logic            cond_last;

   // A start that lands while busy is dropped so the running op finishes intact.
   assign start_go = alu.i_alu_start & ~busy_q;
   assign vld      = start_go | busy_q;
   assign op_cur   = busy_q ? op_q : alu.i_alu_op;
   assign last     = (start_go && (NIBBLES == 1)) ||
                     (busy_q && (ctr_q == CtrW'(NIBBLES - 1)));

   always_comb begin
      cin = 1'b0;
      if (busy_q) begin
         cin = carry_q;
      end else begin
         case (alu.i_alu_op)
            AluSub:  cin = 1'b1;
            AluShlc: cin = cond_q;
            default: cin = 1'b0;
         endcase
      end
   end

   idli_alu_nib_m u_nib (
      .i_b    (alu.i_alu_b_data),
      .i_c    (alu.i_alu_c_data),
      .i_op   (op_cur),
      .i_cin  (cin),
      .o_data (nib_data),
      .o_cout (nib_cout)
   );

   // Zero accumulation restarts at nibble 0 and includes the current nibble.
   assign zero_acc  = (busy_q ? zero_q : 1'b1) & (nib_data == 4'h0);
   assign cond_last = alu_op_cond_from_carry(op_cur) ? nib_cout : ~zero_acc;

   always_comb begin
      busy_d  = busy_q;
      ctr_d   = ctr_q;
      op_d    = op_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      cond_d  = cond_q;

      if (start_go) begin
         op_d   = alu.i_alu_op;
         busy_d = (NIBBLES > 1);
         ctr_d  = (NIBBLES > 1) ? CtrW'(1) : '0;
      end else if (busy_q) begin
         busy_d = ~last;
         ctr_d  = last ? '0 : ctr_q + CtrW'(1);
      end

      if (vld) begin
         carry_d = nib_cout;
         zero_d  = zero_acc;
         if (last) begin
            cond_d = cond_last;
         end
      end
   end

   always_ff @(posedge i_alu_gck or negedge i_alu_rst_n) begin
      if (!i_alu_rst_n) begin
         busy_q  <= 1'b0;
         ctr_q   <= '0;
         op_q    <= AluAdd;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
         cond_q  <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         ctr_q   <= ctr_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         cond_q  <= cond_d;
      end
   end

   assign alu.o_alu_busy = busy_q;
   assign alu.o_alu_vld  = vld;
   assign alu.o_alu_data = nib_data;
   assign alu.o_alu_last = last;
   assign alu.o_alu_cond = cond_q;

   a_no_start_while_busy : assert property (
      @(posedge i_alu_gck) disable iff (!i_alu_rst_n) !(alu.i_alu_start && busy_q)
   ) else $error("idli_alu_m: start asserted while busy");

endmodule
